// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the seven-segment scan driver:
//   NUM_DIGITS_DEFAULT : default number of multiplexed digits (4)
//   SEG_OFF            : all segments dark (active-low gfedcba)
//   SEG_HEX_0..F       : active-low gfedcba patterns for hex digits
//   top_digit()        : index of the most significant non-zero nibble,
//                        0 when the whole word is zero
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    // Highest digit that carries a non-zero nibble; digit 0 when v == 0 so
    // that a zero value still shows a single "0".
    function automatic logic [1:0] top_digit(input logic [15:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble : in  [3:0] hex digit
//   seg    : out [6:0] segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
// Multiplexed four-digit seven-segment driver. A slow scan_clk square wave
// (sampled as data) advances the lit digit once per rising edge; the value
// and decimal points are latched into shadow registers once per frame so a
// frame never mixes old and new data.
//
// Ports:
//   clk        : in  system clock, all state on rising edge
//   rst_n      : in  asynchronous active-low reset
//   scan_clk   : in  slow square wave, synchronised internally
//   value      : in  [15:0] four hex nibbles, digit 0 = value[3:0]
//   dp_in      : in  [3:0] decimal points, active-high, bit i = digit i
//   blank      : in  forces all anodes off while high
//   an         : out [3:0] anode enables, active-low, one-cold
//   seg        : out [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp         : out decimal point, active-low
//   frame_done : out one-cycle pulse when the digit index wraps 3->0
//
// Build option: define LEADING_ZERO_BLANK_EN to darken leading-zero digits
// above the most significant non-zero nibble (digit 0 always lit).
//
// Timing: scan_clk high is first seen by sync1 (edge 1), reaches sync2
// (edge 2), scan_tick then advances digit_idx (edge 3) and the registered
// outputs follow (edge 4).
// -----------------------------------------------------------------------------
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    logic                    sync1;
    logic                    sync2;
    logic                    hist;
    logic                    scan_tick;
    logic                    wrap_tick;
    logic [1:0]              digit_idx;
    logic [4*NUM_DIGITS-1:0] value_shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;
    logic [3:0]              cur_nibble;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   an_onecold;
    logic                    digit_lit;

    // Rising-edge detect on the synchronised scan_clk.
    assign scan_tick = sync2 & ~hist;
    assign wrap_tick = scan_tick && (digit_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= scan_clk;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Digit index and frame-boundary capture. Shadows only move on the wrap
    // so all four digits of one frame come from the same value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx    <= 2'd0;
            value_shadow <= '0;
            dp_shadow    <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= wrap_tick;
            if (scan_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (wrap_tick) begin
                value_shadow <= value;
                dp_shadow    <= dp_in;
            end
        end
    end

    assign cur_nibble = value_shadow[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        an_onecold            = '1;
        an_onecold[digit_idx] = 1'b0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign digit_lit = (digit_idx <= top_digit(value_shadow));
`else
    assign digit_lit = 1'b1;
`endif

    // Outputs re-registered every cycle so blank takes effect (and releases)
    // on the very next edge at whatever digit is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= (blank || !digit_lit) ? '1 : an_onecold;
            seg <= seg_dec;
            dp  <= digit_lit ? ~dp_shadow[digit_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
// Directed bench for seven_seg_scan. Stimulus tasks push the expected output
// word {cycle, an, seg, dp} each time the display should change, and the
// expected frame_done cycle at each wrap. A negedge monitor pops and compares
// whenever the DUT outputs change or frame_done is high.
// Define LEADING_ZERO_BLANK_EN to also run the leading-zero vectors.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int W = 44;   // 32-bit cycle stamp + an(4) + seg(7) + dp(1)

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [11:0] RESET_OUT = {4'b1111, 7'b1111111, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_clk;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           fd_q[$];

    // Bench model of the display state
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_blank;
    logic [11:0] last_exp;

    seven_seg_scan #(.NUM_DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_clk   (scan_clk),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model / driver tasks ----------------
    function automatic logic [11:0] model_out();
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        logic       lit;
        logic [3:0] nib;
        lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 1; i < 4; i++) if (m_val[4*i +: 4] != 4'h0) msd = i;
            lit = (m_idx <= msd);
        end
`endif
        nib = m_val[4*m_idx +: 4];
        s = SEG_TAB[nib];
        a = 4'b1111;
        if (!m_blank && lit) a[m_idx] = 1'b0;
        d = lit ? ~m_dp[m_idx] : 1'b1;
        return {a, s, d};
    endfunction

    task automatic expect_out(input int c);
        logic [11:0] e;
        e = model_out();
        if (e != last_exp) begin
            exp_q.push_back({c, e});
            last_exp = e;
        end
    endtask

    task automatic model_tick(input int n);
        // n = first edge that samples scan_clk high; tick lands on edge n+2
        if (m_idx == 3) begin
            m_val = value;
            m_dp  = dp_in;
            fd_q.push_back(n + 2);
        end
        m_idx = (m_idx + 1) % 4;
        expect_out(n + 3);
    endtask

    task automatic scan_pulse(input int hi, input int lo);
        int n;
        @(negedge clk);
        scan_clk = 1'b1;
        n = cyc + 1;
        model_tick(n);
        repeat (hi) @(negedge clk);
        scan_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic set_blank(input logic b);
        @(negedge clk);
        blank   = b;
        m_blank = b;
        expect_out(cyc + 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic model_reset();
        m_idx    = 0;
        m_val    = 16'h0000;
        m_dp     = 4'b0000;
        last_exp = RESET_OUT;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({an, seg, dp} !== RESET_OUT) begin
            errors++;
            $display("FAIL %s_outputs: got an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1",
                     tag, an, seg, dp);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_frame_done: got %b, required 0", tag, frame_done);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [11:0] prev_out;

    always @(negedge clk) begin
        logic [11:0]  cur;
        logic [W-1:0] e;
        int           fd_exp;
        cur = {an, seg, dp};
        if (!rst_n) begin
            prev_out = cur;
        end else begin
            if (cur !== prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL display_change: cycle %0d got an=%b seg=%b dp=%b, required no change",
                             cyc, an, seg, dp);
                end else begin
                    e = exp_q.pop_front();
                    if (e[43:12] != cyc || e[11:0] !== cur) begin
                        errors++;
                        $display("FAIL display_change: cycle %0d got an=%b seg=%b dp=%b, required cycle %0d an=%b seg=%b dp=%b",
                                 cyc, an, seg, dp, e[43:12], e[11:8], e[7:1], e[0]);
                    end
                end
                prev_out = cur;
            end
            if (frame_done === 1'b1) begin
                checks++;
                if (fd_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done: pulse at cycle %0d, required none", cyc);
                end else begin
                    fd_exp = fd_q.pop_front();
                    if (fd_exp != cyc) begin
                        errors++;
                        $display("FAIL frame_done: pulse at cycle %0d, required cycle %0d", cyc, fd_exp);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int k;
        rst_n    = 1'b0;
        scan_clk = 1'b0;
        value    = 16'h1234;
        dp_in    = 4'b0101;
        blank    = 1'b0;
        m_blank  = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Release with scan_clk low: outputs load digit 0 of zero shadows
        @(negedge clk);
        rst_n = 1'b1;
        expect_out(cyc + 1);
        repeat (3) @(negedge clk);

        // Four ticks to reach the first wrap (captures 1234), then a frame
        repeat (4) scan_pulse(3, 4);
        repeat (4) scan_pulse(3, 4);

        // Long high: exactly one step, output on the 4th edge
        scan_pulse(10, 4);

        // Now at digit 1; step to digit 2, then change value mid-frame
        scan_pulse(3, 4);
        @(negedge clk);
        value = 16'hABCD;
        dp_in = 4'b1010;
        repeat (4) scan_pulse(2, 4);

        // Blank across three ticks, then release
        set_blank(1'b1);
        repeat (3) scan_pulse(3, 4);
        set_blank(1'b0);
        scan_pulse(3, 4);

        // Mid-frame reset, released with scan_clk already high
        scan_pulse(3, 4);
        @(negedge clk);
        rst_n    = 1'b0;
        scan_clk = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc + 1;
        expect_out(k);
        model_tick(k);
        repeat (4) @(negedge clk);
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
        repeat (3) scan_pulse(3, 4);
        repeat (4) scan_pulse(3, 4);

`ifdef LEADING_ZERO_BLANK_EN
        @(negedge clk);
        value = 16'h0050;
        dp_in = 4'b1111;
        repeat (8) scan_pulse(3, 4);
        @(negedge clk);
        value = 16'h0000;
        dp_in = 4'b0000;
        repeat (8) scan_pulse(3, 4);
`endif

        // Drain: everything expected must have been seen
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || fd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d display and %0d frame_done entries left, required 0 and 0",
                     exp_q.size(), fd_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
